// File: rtl/fifo_rr_arbiter_pkg.sv
// Shared definitions for the FIFO round-robin arbiter: FSM encoding and width helpers.
package fifo_rr_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    // Index width that stays legal (>= 1 bit) even for a single entry.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned max_count);
        return $clog2(max_count) + 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set bit of req_i at or after ptr_i, wrapping.
module rr_priority_picker
    import fifo_rr_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     ptr_i,
    output logic               found_o,
    output logic [IDW-1:0]     idx_o
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int k;
            k = int'(ptr_i) + i;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            if (!found_o && req_i[k]) begin
                found_o = 1'b1;
                idx_o   = IDW'(k);
            end
        end
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter draining NUM_REQ show-ahead source FIFOs into one destination FIFO.
module fifo_rr_arbiter
    import fifo_rr_arbiter_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int MAX_BURST  = 256,
    localparam int IDW        = idx_width(NUM_REQ),
    localparam int CNTW       = cnt_width(MAX_BURST)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_empty_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    output logic [NUM_REQ-1:0]            req_rd_o,
    input  logic                          dst_full_i,
    output logic [DATA_WIDTH-1:0]         dst_data_o,
    output logic                          dst_wr_o,
    output logic                          grant_valid_o,
    output logic [IDW-1:0]                grant_id_o,
    output logic [CNTW-1:0]               beat_cnt_o
);

    arb_state_e      state_q, state_d;
    logic [IDW-1:0]  grant_id_q, grant_id_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNTW-1:0] beat_cnt_q, beat_cnt_d;

    logic            pick_found;
    logic [IDW-1:0]  pick_idx;
    logic            xfer;
    logic            grant_end;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req_i   (~req_empty_i),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // Strobes are gated by rst_n so nothing is popped or written during a reset cycle.
    assign xfer      = rst_n && (state_q == ST_BURST) && !req_empty_i[grant_id_q] && !dst_full_i;
    assign grant_end = req_last_i[grant_id_q] || (beat_cnt_q == CNTW'(MAX_BURST - 1));

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d    = ST_BURST;
                    grant_id_d = pick_idx;
                    beat_cnt_d = '0;
                end
            end
            ST_BURST: begin
                if (xfer) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (grant_end) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        req_rd_o = '0;
        if (xfer) req_rd_o[grant_id_q] = 1'b1;
    end

    assign dst_wr_o      = xfer;
    assign dst_data_o    = req_data_i[int'(grant_id_q) * DATA_WIDTH +: DATA_WIDTH];
    assign grant_valid_o = (state_q == ST_BURST);
    assign grant_id_o    = grant_id_q;
    assign beat_cnt_o    = beat_cnt_q;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Self-checking bench for fifo_rr_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_fifo_rr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DW        = 8;
    localparam int MAX_BURST = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [3:0]        req_empty_i;
    logic [31:0]       req_data_i;
    logic [3:0]        req_last_i;
    logic [3:0]        req_rd_o;
    logic              dst_full_i;
    logic [7:0]        dst_data_o;
    logic              dst_wr_o;
    logic              grant_valid_o;
    logic [1:0]        grant_id_o;
    logic [2:0]        beat_cnt_o;

    fifo_rr_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MAX_BURST)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_empty_i   (req_empty_i),
        .req_data_i    (req_data_i),
        .req_last_i    (req_last_i),
        .req_rd_o      (req_rd_o),
        .dst_full_i    (dst_full_i),
        .dst_data_o    (dst_data_o),
        .dst_wr_o      (dst_wr_o),
        .grant_valid_o (grant_valid_o),
        .grant_id_o    (grant_id_o),
        .beat_cnt_o    (beat_cnt_o)
    );

    always #5 clk = ~clk;

    // Source FIFO contents: bit 8 is the last-beat flag, bits 7:0 the payload.
    logic [8:0] src_q [NUM_REQ][$];
    logic [7:0] got_q [$];
    int         gid_q [$];

    bit         rst_v, full_v;
    bit [3:0]   hold_v;
    int         n_vec, n_err;

    // Reference model state: who owns the destination, beats so far, scan start.
    bit         m_busy;
    int         m_gid, m_cnt, m_ptr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive();
        rst_n      = rst_v;
        dst_full_i = full_v;
        for (int k = 0; k < NUM_REQ; k++) begin
            req_empty_i[k] = (src_q[k].size() == 0) || hold_v[k];
            if (src_q[k].size() > 0) begin
                req_data_i[k*DW +: DW] = src_q[k][0][7:0];
                req_last_i[k]          = src_q[k][0][8];
            end else begin
                req_data_i[k*DW +: DW] = '0;
                req_last_i[k]          = 1'b0;
            end
        end
    endtask

    task automatic step(input bit chk);
        bit         exp_xfer;
        logic [3:0] exp_rd;
        logic [8:0] w;
        @(negedge clk);
        drive();
        #1;
        exp_xfer = rst_v && m_busy && !req_empty_i[m_gid] && !full_v;
        exp_rd   = exp_xfer ? 4'(1 << m_gid) : 4'b0;
        if (chk) begin
            check("grant_valid", grant_valid_o, m_busy);
            check("grant_id", grant_id_o, m_gid);
            check("beat_cnt", beat_cnt_o, m_cnt);
            check("req_rd", req_rd_o, exp_rd);
            check("dst_wr", dst_wr_o, exp_xfer);
            check("rd_onehot", $onehot0(req_rd_o), 1);
            if (exp_xfer) check("dst_data", dst_data_o, src_q[m_gid][0][7:0]);
        end
        if (dst_wr_o === 1'b1) begin
            got_q.push_back(dst_data_o);
            gid_q.push_back(int'(grant_id_o));
        end
        if (!rst_v) begin
            m_busy = 0; m_gid = 0; m_cnt = 0; m_ptr = 0;
        end else if (!m_busy) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                int k;
                k = (m_ptr + i) % NUM_REQ;
                if (!req_empty_i[k]) begin
                    m_busy = 1; m_gid = k; m_cnt = 0;
                    break;
                end
            end
        end else if (exp_xfer) begin
            w = src_q[m_gid].pop_front();
            m_cnt++;
            if (w[8] || m_cnt == MAX_BURST) begin
                m_busy = 0;
                m_ptr  = (m_gid + 1) % NUM_REQ;
            end
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        rst_v  = 0;
        full_v = 0;
        hold_v = '0;
        for (int k = 0; k < NUM_REQ; k++) src_q[k].delete();
        step(1);
        rst_v = 1;
        got_q.delete();
        gid_q.delete();
    endtask

    task automatic push_burst(input int k, input int len, input bit with_last, input logic [7:0] base);
        for (int i = 0; i < len; i++)
            src_q[k].push_back({(with_last && i == len - 1), 8'(base + i)});
    endtask

    task automatic wait_writes(input int n, input int budget, input string tag);
        int c = 0;
        while (got_q.size() < n && c < budget) begin
            step(1);
            c++;
        end
        check(tag, got_q.size() >= n, 1);
    endtask

    task automatic check_stream(input string tag, input logic [7:0] words [], input int ids []);
        check({tag, "_count"}, got_q.size(), words.size());
        for (int i = 0; i < words.size() && i < got_q.size(); i++) begin
            check({tag, "_word"}, got_q[i], words[i]);
            check({tag, "_gid"}, gid_q[i], ids[i]);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_v = 0; full_v = 0; hold_v = '0;
        step(0);
        do_reset();

        // All requesters empty: nothing granted or moved.
        repeat (10) step(1);
        check("idle_writes", got_q.size(), 0);

        // Requesters 0 and 2 each hold a 3-beat burst.
        push_burst(0, 3, 1, 8'h10);
        push_burst(2, 3, 1, 8'h20);
        repeat (12) step(1);
        check_stream("two_bursts", '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22}, '{0, 0, 0, 2, 2, 2});

        // Every requester always has single-beat bursts: strict rotation, one beat per two cycles.
        do_reset();
        for (int k = 0; k < NUM_REQ; k++) begin
            push_burst(k, 1, 1, 8'(8'h30 + 4 * k));
            push_burst(k, 1, 1, 8'(8'h31 + 4 * k));
            push_burst(k, 1, 1, 8'(8'h32 + 4 * k));
        end
        repeat (10) step(1);
        check("rotation_writes", got_q.size(), 5);
        for (int i = 0; i < 5 && i < gid_q.size(); i++) check("rotation_gid", gid_q[i], i % NUM_REQ);
        repeat (16) step(1);

        // Destination full for 5 cycles during beat 2 of a 4-beat burst.
        do_reset();
        push_burst(1, 4, 1, 8'h50);
        wait_writes(1, 10, "stall_first_beat");
        full_v = 1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("stall_beat_cnt", beat_cnt_o, 1);
        end
        full_v = 0;
        repeat (8) step(1);
        check_stream("stall", '{8'h50, 8'h51, 8'h52, 8'h53}, '{1, 1, 1, 1});

        // Long stream without a last flag is cut at MAX_BURST and requester 3 gets its turn.
        do_reset();
        push_burst(1, 6, 0, 8'h60);
        push_burst(3, 2, 1, 8'h70);
        repeat (20) step(1);
        check_stream("max_burst", '{8'h60, 8'h61, 8'h62, 8'h63, 8'h70, 8'h71, 8'h64, 8'h65},
                     '{1, 1, 1, 1, 3, 3, 1, 1});

        // Reset pulse at beat 2 of a grant to requester 2.
        do_reset();
        push_burst(2, 4, 1, 8'h80);
        push_burst(3, 1, 1, 8'h90);
        wait_writes(1, 10, "rst_first_beat");
        check("rst_pre_gid", gid_q[0], 2);
        push_burst(1, 1, 1, 8'hA0);
        rst_v = 0;
        step(1);
        rst_v = 1;
        #1;
        check("rst_grant_valid", grant_valid_o, 0);
        check("rst_grant_id", grant_id_o, 0);
        check("rst_beat_cnt", beat_cnt_o, 0);
        wait_writes(2, 10, "rst_second_beat");
        if (gid_q.size() >= 2) begin
            check("rst_new_gid", gid_q[1], 1);
            check("rst_new_word", got_q[1], 8'hA0);
        end

        // Random traffic, stalls, flickering empties and occasional resets.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(3) == 0) begin
                int k;
                k = $urandom_range(NUM_REQ - 1);
                if (src_q[k].size() < 24)
                    push_burst(k, $urandom_range(1, 6), $urandom_range(3) != 0, 8'($urandom));
            end
            full_v = ($urandom_range(3) == 0);
            for (int k = 0; k < NUM_REQ; k++) hold_v[k] = ($urandom_range(7) == 0);
            rst_v = ($urandom_range(499) != 0);
            step(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_rr_arbiter.md
FIFO_RR_ARBITER -- requirements
Module: fifo_rr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, meaning number of requester FIFOs (2..16).
REQ-002 Parameter DATA_WIDTH, default 8, meaning payload width per beat.
REQ-003 Parameter MAX_BURST, default 256, meaning maximum beats per grant before forced release.
REQ-004 clk  input  1  clock, all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 req_empty_i  input  NUM_REQ  per-requester source FIFO empty flag.
REQ-007 req_data_i  input  NUM_REQ*DATA_WIDTH  packed source FIFO head words, requester k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_last_i  input  NUM_REQ  per-requester flag marking the head word as the last beat of a burst.
REQ-009 req_rd_o  output  NUM_REQ  one-hot read strobe to source FIFOs.
REQ-010 dst_full_i  input  1  destination FIFO full flag.
REQ-011 dst_data_o  output  DATA_WIDTH  word written to destination FIFO.
REQ-012 dst_wr_o  output  1  write strobe to destination FIFO.
REQ-013 grant_valid_o  output  1  a requester currently owns the destination.
REQ-014 grant_id_o  output  $clog2(NUM_REQ)  index of the owning requester.
REQ-015 beat_cnt_o  output  $clog2(MAX_BURST)+1  beats transferred in the current grant.

Function
REQ-016 Source FIFOs are show-ahead: head word is valid combinationally whenever the empty flag is low; a read strobe pops it at the next edge.
REQ-017 FSM states are IDLE and BURST.
REQ-018 IDLE: the block scans requesters starting at rr_ptr, wrapping modulo NUM_REQ, and selects the first with req_empty_i low; if one is found, it registers grant_id_o, sets grant_valid_o, clears beat_cnt_o and enters BURST at the next edge; otherwise it stays in IDLE.
REQ-019 Arbitration latency is exactly one cycle (IDLE to BURST); no beat transfers in IDLE.
REQ-020 BURST: a beat transfers in a cycle iff req_empty_i[grant_id_o]==0 and dst_full_i==0; in that cycle req_rd_o[grant_id_o]=1, dst_wr_o=1, dst_data_o=req_data_i slice of grant_id_o, all combinational.
REQ-021 In any cycle without a transfer, req_rd_o is all-zero and dst_wr_o is 0; dst_data_o is don't-care.
REQ-022 Each transfer increments beat_cnt_o by one.
REQ-023 A transfer with req_last_i[grant_id_o]==1, or a transfer that makes beat_cnt_o equal MAX_BURST, ends the grant: next state IDLE, grant_valid_o=0, rr_ptr=(grant_id_o+1) mod NUM_REQ.
REQ-024 A granted requester going empty mid-burst keeps the grant; the block waits in BURST with no timeout.
REQ-025 dst_full_i high stalls the transfer; the grant, beat_cnt_o and the FIFO heads remain unchanged.
REQ-026 Changes in req_empty_i of non-granted requesters during BURST have no effect.
REQ-027 At most one bit of req_rd_o is high in any cycle.

Reset
REQ-028 While rst_n is low at a clock edge: state=IDLE, rr_ptr=0, grant_valid_o=0, grant_id_o=0, beat_cnt_o=0; req_rd_o=0 and dst_wr_o=0 in that cycle.
REQ-029 Reset asserted mid-burst abandons the burst; the first grant after release starts from requester 0.

Structure
REQ-030 The FSM state encoding and a clog2-width helper constant are placed in the shared interconnect package.
REQ-031 One sub-module, rr_priority_picker (combinational rotate-and-find-first over NUM_REQ bits given rr_ptr), is instantiated for the IDLE scan; all other logic is flat.

Verification
REQ-032 Reset, then all requesters empty for 10 cycles -> grant_valid_o=0, req_rd_o=0, dst_wr_o=0 throughout.
REQ-033 Requesters 0 and 2 each hold a 3-beat burst (last on beat 3) with the destination never full -> grant 0 for 3 beats, 1 idle cycle, grant 2 for 3 beats, destination receives 6 words in order.
REQ-034 All 4 requesters continuously non-empty, each burst 1 beat -> grant order 0,1,2,3,0, one beat every 2 cycles.
REQ-035 dst_full_i held high for 5 cycles during beat 2 of a 4-beat burst -> no strobes for 5 cycles, beat_cnt_o holds at 1, and the burst resumes and completes with 4 words.
REQ-036 MAX_BURST=4, requester 1 streams 6 words with no last flag while requester 3 is non-empty -> release after 4 beats, grant moves to 3, and requester 1 is served again later.
REQ-037 rst_n pulsed low at beat 2 of a grant to requester 2 -> all outputs are 0 the next cycle, and the first new grant goes to the lowest-index non-empty requester.
